channel_phase_ctrl: RTL

Per-channel oscillator controller for the synth datapath. Accepts note commands over a valid/ready handshake and runs a programmable clock divider and an M-bit phase counter. The phase counter drives the `period` input of the channel's waveform generators, e.g. the square generator, which takes the phase MSB. On note-off the controller finishes the current waveform cycle before silencing, so gating never truncates a waveform mid-cycle.

---
 rtl/channel_phase_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/channel_phase_ctrl.sv
// channel_phase_ctrl: per-channel oscillator controller.
// Accepts note commands over valid/ready and runs a clock divider plus an
// M-bit phase counter. A note-off lets the current waveform cycle finish
// (DRAIN) before the channel is silenced.
module channel_phase_ctrl #(
  parameter int unsigned M = 6,
  parameter int unsigned D = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [D-1:0] cmd_div,
  output logic [M-1:0] phase,
  output logic         gate,
  output logic         wrap,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [1:0] OP_NOTE_ON  = 2'd1;
  localparam logic [1:0] OP_NOTE_OFF = 2'd2;

  state_t       state, state_n;
  logic [D-1:0] div_reg, div_n;
  logic [D-1:0] tick, tick_n;
  logic [M-1:0] phase_n;
  logic         gate_n, wrap_n, err_n;
  logic         accept, note_on, note_off, div_zero, tick_last, phase_last;

  // Command decode; cmd_ready depends on the state register only.
  always_comb begin
    cmd_ready  = (state != DRAIN);
    accept     = cmd_valid && cmd_ready;
    note_on    = accept && (cmd_op == OP_NOTE_ON);
    note_off   = accept && (cmd_op == OP_NOTE_OFF);
    div_zero   = (cmd_div == '0);
    tick_last  = (tick == div_reg - 1'b1);
    phase_last = (phase == '1);
  end

  // Next-state and datapath: ticking is computed first, then command
  // handling overrides it where a command takes precedence.
  always_comb begin
    state_n = state;
    div_n   = div_reg;
    tick_n  = tick;
    phase_n = phase;
    wrap_n  = 1'b0;
    err_n   = 1'b0;

    if (state != IDLE) begin
      if (tick_last) begin
        tick_n  = '0;
        phase_n = phase + 1'b1;
        wrap_n  = phase_last;
      end else begin
        tick_n = tick + 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (note_on && !div_zero) begin
          div_n   = cmd_div;
          tick_n  = '0;
          phase_n = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (note_on && !div_zero) begin
          // Retrigger: restart the divider but hold phase on this edge.
          div_n   = cmd_div;
          tick_n  = '0;
          phase_n = phase;
          wrap_n  = 1'b0;
        end else if (note_off) begin
          if (phase == '0) begin
            state_n = IDLE;
            tick_n  = '0;
            phase_n = '0;
            wrap_n  = 1'b0;
          end else begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (tick_last && phase_last) begin
          state_n = IDLE;
          tick_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (note_on && div_zero) begin
      err_n = 1'b1;
    end

    gate_n = (state_n != IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_reg <= '0;
      tick    <= '0;
      phase   <= '0;
      gate    <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      div_reg <= div_n;
      tick    <= tick_n;
      phase   <= phase_n;
      gate    <= gate_n;
      wrap    <= wrap_n;
      err     <= err_n;
    end
  end

endmodule
